// File: rtl/ik_swift_pkg.sv
// Shared widths, state encoding and saturating arithmetic for the IK iteration sequencer.
package ik_swift_pkg;

  localparam int W        = 36;
  localparam int N_JOINT  = 6;
  localparam int N_POSE   = 6;
  localparam int MAX_ITER = 16;

  typedef logic signed [W-1:0] data_t;

  localparam data_t TOL      = 36'sd256;
  localparam data_t DATA_MAX = {1'b0, {(W-1){1'b1}}};
  localparam data_t DATA_MIN = {1'b1, {(W-1){1'b0}}};

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_JAC_REQ  = 3'd1;
  localparam state_t S_JAC_WAIT = 3'd2;
  localparam state_t S_CHECK    = 3'd3;
  localparam state_t S_SLV_REQ  = 3'd4;
  localparam state_t S_SLV_WAIT = 3'd5;
  localparam state_t S_UPDATE   = 3'd6;

  // One guard bit; overflow shows as a mismatch between the two top bits.
  function automatic data_t sat_add(input data_t a, input data_t b);
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) sat_add = s[W] ? DATA_MIN : DATA_MAX;
    else                sat_add = s[W-1:0];
  endfunction

  function automatic data_t sat_sub(input data_t a, input data_t b);
    logic signed [W:0] s;
    s = {a[W-1], a} - {b[W-1], b};
    if (s[W] != s[W-1]) sat_sub = s[W] ? DATA_MIN : DATA_MAX;
    else                sat_sub = s[W-1:0];
  endfunction

  function automatic data_t sat_abs(input data_t a);
    if (a == DATA_MIN)  sat_abs = DATA_MAX;
    else if (a[W-1])    sat_abs = -a;
    else                sat_abs = a;
  endfunction

endpackage

// File: rtl/ik_swift_core_addsub.sv
// Element-wise saturating add (SUB=0) or subtract (SUB=1) over N packed signed words.
module ik_vec_sat_addsub
  import ik_swift_pkg::*;
#(
  parameter int N   = 6,
  parameter bit SUB = 1'b0
) (
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  output logic [N*W-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) begin
      if (SUB) y[i*W +: W] = sat_sub(data_t'(a[i*W +: W]), data_t'(b[i*W +: W]));
      else     y[i*W +: W] = sat_add(data_t'(a[i*W +: W]), data_t'(b[i*W +: W]));
    end
  end

endmodule

// File: rtl/ik_swift_core.sv
// IK iteration sequencer: FK -> error -> convergence test -> solve -> saturating angle update.
//   state    | meaning
//   IDLE     | result held, waiting for start
//   JAC_REQ  | jac_start pulse
//   JAC_WAIT | waiting for jac_done, then register error
//   CHECK    | tolerance / iteration-limit decision
//   SLV_REQ  | slv_start pulse
//   SLV_WAIT | waiting for slv_done, then capture dtheta
//   UPDATE   | theta += dtheta (saturated), iter_count++
module ik_swift_core
  import ik_swift_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_JOINT*W-1:0]   theta_in,
  input  logic [N_POSE*W-1:0]    target_in,
  output logic                   busy,
  output logic                   done,
  output logic                   converged,
  output logic [7:0]             iter_count,
  output logic [N_JOINT*W-1:0]   theta_out,
  output logic                   jac_start,
  output logic [N_JOINT*W-1:0]   jac_theta,
  input  logic                   jac_done,
  input  logic [N_POSE*W-1:0]    jac_pos,
  output logic                   slv_start,
  output logic [N_POSE*W-1:0]    slv_err,
  input  logic                   slv_done,
  input  logic [N_JOINT*W-1:0]   slv_dtheta
);

  state_t                 state;
  logic [N_JOINT*W-1:0]   theta_q;
  logic [N_JOINT*W-1:0]   dtheta_q;
  logic [N_JOINT*W-1:0]   theta_nx;
  logic [N_POSE*W-1:0]    target_q;
  logic [N_POSE*W-1:0]    err_q;
  logic [N_POSE*W-1:0]    err_nx;
  logic                   within_tol;

  ik_vec_sat_addsub #(.N(N_POSE), .SUB(1'b1)) u_err (
    .a (target_q),
    .b (jac_pos),
    .y (err_nx)
  );

  ik_vec_sat_addsub #(.N(N_JOINT), .SUB(1'b0)) u_upd (
    .a (theta_q),
    .b (dtheta_q),
    .y (theta_nx)
  );

  always_comb begin
    within_tol = 1'b1;
    for (int i = 0; i < N_POSE; i++) begin
      if (sat_abs(data_t'(err_q[i*W +: W])) >= TOL) within_tol = 1'b0;
    end
  end

  assign theta_out = theta_q;
  assign jac_theta = theta_q;
  assign slv_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      converged  <= 1'b0;
      jac_start  <= 1'b0;
      slv_start  <= 1'b0;
      iter_count <= '0;
      theta_q    <= '0;
      target_q   <= '0;
      err_q      <= '0;
      dtheta_q   <= '0;
    end else begin
      jac_start <= 1'b0;
      slv_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            theta_q    <= theta_in;
            target_q   <= target_in;
            iter_count <= '0;
            converged  <= 1'b0;
            jac_start  <= 1'b1;
            busy       <= 1'b1;
            state      <= S_JAC_REQ;
          end
        end
        S_JAC_REQ: state <= S_JAC_WAIT;
        S_JAC_WAIT: begin
          if (jac_done) begin
            err_q <= err_nx;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (within_tol) begin
            converged <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (iter_count == 8'(MAX_ITER)) begin
            converged <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            slv_start <= 1'b1;
            state     <= S_SLV_REQ;
          end
        end
        S_SLV_REQ: state <= S_SLV_WAIT;
        S_SLV_WAIT: begin
          if (slv_done) begin
            dtheta_q <= slv_dtheta;
            state    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          theta_q    <= theta_nx;
          iter_count <= iter_count + 8'd1;
          jac_start  <= 1'b1;
          state      <= S_JAC_REQ;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ik_swift_core.sv
// Directed-plus-random bench: stub engines answer handshakes, a longint model tracks the iteration.
module tb_ik_swift_core;
  import ik_swift_pkg::*;

  localparam int     JW   = N_JOINT*W;
  localparam int     PW   = N_POSE*W;
  localparam longint SMAX = (64'sd1 <<< (W-1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (W-1));
  localparam logic [W-1:0] MAXW = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINW = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst, start, jac_done, slv_done;
  logic [JW-1:0] theta_in, jac_theta, theta_out, slv_dtheta;
  logic [PW-1:0] target_in, jac_pos, slv_err;
  logic busy, done, converged, jac_start, slv_start;
  logic [7:0] iter_count;

  int vectors = 0, miscompares = 0;
  int jcnt = 0, scnt = 0;
  longint m_theta[N_JOINT];
  longint m_target[N_POSE];
  longint m_pos[N_POSE];
  longint m_err[N_POSE];
  int m_iter;
  bit m_conv;
  int pm, dm;

  ik_swift_core dut (
    .clk(clk), .rst(rst), .start(start), .theta_in(theta_in), .target_in(target_in),
    .busy(busy), .done(done), .converged(converged), .iter_count(iter_count),
    .theta_out(theta_out), .jac_start(jac_start), .jac_theta(jac_theta),
    .jac_done(jac_done), .jac_pos(jac_pos), .slv_start(slv_start), .slv_err(slv_err),
    .slv_done(slv_done), .slv_dtheta(slv_dtheta)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (jac_start) jcnt <= jcnt + 1;
    if (slv_start) scnt <= scnt + 1;
  end

  task automatic chk(input string tag, input logic [JW-1:0] obs, input logic [JW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  function automatic longint absl(input longint v);
    return (v < 0) ? sat(-v) : v;
  endfunction

  function automatic longint rnd20();
    return longint'($urandom_range(0, 2097152)) - 64'sd1048576;
  endfunction

  function automatic logic [JW-1:0] rnd_vec();
    logic [JW-1:0] v;
    for (int i = 0; i < N_JOINT; i++) v[i*W +: W] = {4'($urandom), $urandom};
    return v;
  endfunction

  function automatic logic [JW-1:0] pack_theta();
    logic [JW-1:0] v;
    for (int i = 0; i < N_JOINT; i++) v[i*W +: W] = m_theta[i][W-1:0];
    return v;
  endfunction

  function automatic logic [PW-1:0] pack_err();
    logic [PW-1:0] v;
    for (int i = 0; i < N_POSE; i++) v[i*W +: W] = m_err[i][W-1:0];
    return v;
  endfunction

  // Stub plant: pose as a function of the current angles and target.
  function automatic longint plant_pos(input int i);
    case (pm)
      0:       return m_target[i];
      1:       return m_theta[i];
      2:       return m_target[i] - 5000;
      default: return 1;
    endcase
  endfunction

  function automatic longint plant_dth(input int i);
    case (dm)
      0:       return m_err[i];
      1:       return 0;
      2:       return 100;
      default: return m_err[i] >>> 1;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic run_case(input bit poke);
    int j0, s0;
    bit fin;
    longint t;
    fin = 1'b0;
    do_reset();
    for (int i = 0; i < N_JOINT; i++) theta_in[i*W +: W] = m_theta[i][W-1:0];
    for (int i = 0; i < N_POSE; i++)  target_in[i*W +: W] = m_target[i][W-1:0];
    j0 = jcnt; s0 = scnt; m_iter = 0; m_conv = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("jac_start_after_start", jac_start, 1'b1);
    chk("busy_after_start", busy, 1'b1);
    for (int k = 0; k <= MAX_ITER && !fin; k++) begin
      chk("jac_theta", jac_theta, pack_theta());
      repeat ($urandom_range(1, 3)) @(negedge clk);
      if (poke && k == 0) begin
        start = 1'b1; theta_in = rnd_vec(); target_in = rnd_vec();
        @(negedge clk); start = 1'b0;
      end
      for (int i = 0; i < N_POSE; i++) begin
        m_pos[i] = plant_pos(i);
        m_err[i] = sat(m_target[i] - m_pos[i]);
        jac_pos[i*W +: W] = m_pos[i][W-1:0];
      end
      jac_done = 1'b1; @(negedge clk); jac_done = 1'b0; jac_pos = rnd_vec();
      chk("no_early_response", {done, slv_start}, 2'b00);
      @(negedge clk);
      m_conv = 1'b1;
      for (int i = 0; i < N_POSE; i++) if (absl(m_err[i]) >= 256) m_conv = 1'b0;
      if (m_conv || m_iter == MAX_ITER) begin
        chk("done_pulse", {done, slv_start, busy}, 3'b100);
        chk("converged", converged, m_conv);
        fin = 1'b1;
      end else begin
        chk("slv_start", {done, slv_start}, 2'b01);
        chk("slv_err", slv_err, pack_err());
        repeat ($urandom_range(1, 3)) @(negedge clk);
        for (int i = 0; i < N_JOINT; i++) begin
          t = plant_dth(i);
          slv_dtheta[i*W +: W] = t[W-1:0];
          m_theta[i] = sat(m_theta[i] + t);
        end
        slv_done = 1'b1; @(negedge clk); slv_done = 1'b0; slv_dtheta = rnd_vec();
        @(negedge clk);
        m_iter++;
        chk("jac_start_after_update", jac_start, 1'b1);
        chk("theta_update", theta_out, pack_theta());
      end
    end
    chk("iter_count", iter_count, m_iter);
    chk("theta_final", theta_out, pack_theta());
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    repeat (4) @(negedge clk);
    chk("result_held", {busy, converged}, {1'b0, m_conv});
    chk("jac_start_count", jcnt - j0, m_iter + 1);
    chk("slv_start_count", scnt - s0, m_iter);
  endtask

  initial begin
    int j0, s0;
    rst = 1'b1; start = 1'b0; jac_done = 1'b0; slv_done = 1'b0;
    jac_pos = '0; slv_dtheta = '0; theta_in = '0; target_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_flags", {busy, done, converged, jac_start, slv_start}, 5'b0);
    chk("reset_iter", iter_count, 8'd0);
    chk("reset_theta", theta_out, '0);
    chk("reset_err", slv_err, '0);

    // Immediate convergence
    pm = 0; dm = 0;
    for (int i = 0; i < N_JOINT; i++) begin m_theta[i] = rnd20(); m_target[i] = rnd20(); end
    run_case(1'b0);
    chk("imm_theta_eq_in", theta_out, theta_in);
    chk("imm_iter_zero", iter_count, 8'd0);

    // Linear plant, solve returns the error
    pm = 1; dm = 0;
    for (int i = 0; i < N_JOINT; i++) begin m_theta[i] = 0; m_target[i] = 1000; end
    run_case(1'b0);
    chk("lin_iter_one", iter_count, 8'd1);
    chk("lin_conv", converged, 1'b1);

    // Non-convergence: error pinned at 5000
    pm = 2; dm = 1;
    for (int i = 0; i < N_JOINT; i++) begin m_theta[i] = rnd20(); m_target[i] = rnd20(); end
    run_case(1'b0);
    chk("nc_iter_16", iter_count, 8'd16);
    chk("nc_not_conv", converged, 1'b0);

    // Angle saturation at the positive rail
    pm = 2; dm = 2;
    for (int i = 0; i < N_JOINT; i++) begin m_theta[i] = rnd20(); m_target[i] = rnd20(); end
    m_theta[0] = SMAX - 9;
    run_case(1'b0);
    chk("theta_clamp_max", theta_out[W-1:0], MAXW);

    // Error saturation at the negative rail
    pm = 3; dm = 1;
    for (int i = 0; i < N_JOINT; i++) begin m_theta[i] = rnd20(); m_target[i] = SMIN; end
    run_case(1'b0);
    chk("err_clamp_min", slv_err[W-1:0], MINW);

    // Random converging plant with halving solver
    pm = 1; dm = 3;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N_JOINT; i++) begin m_theta[i] = rnd20(); m_target[i] = rnd20(); end
      run_case(1'b0);
    end

    // start pulsed while busy must not restart or relatch
    pm = 1; dm = 0;
    for (int i = 0; i < N_JOINT; i++) begin m_theta[i] = rnd20(); m_target[i] = rnd20(); end
    run_case(1'b1);

    // Reset while waiting on the solver, followed by a late slv_done
    pm = 2; dm = 1;
    for (int i = 0; i < N_JOINT; i++) begin m_theta[i] = rnd20() + 7; m_target[i] = rnd20(); end
    do_reset();
    for (int i = 0; i < N_JOINT; i++) theta_in[i*W +: W] = m_theta[i][W-1:0];
    for (int i = 0; i < N_POSE; i++)  target_in[i*W +: W] = m_target[i][W-1:0];
    start = 1'b1; @(negedge clk); start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N_POSE; i++) jac_pos[i*W +: W] = m_target[i][W-1:0] - 36'd5000;
    jac_done = 1'b1; @(negedge clk); jac_done = 1'b0;
    @(negedge clk);
    chk("rst_case_slv_start", slv_start, 1'b1);
    @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_theta", theta_out, '0);
    chk("abort_iter", iter_count, 8'd0);
    j0 = jcnt; s0 = scnt;
    slv_dtheta = rnd_vec(); slv_done = 1'b1; @(negedge clk); slv_done = 1'b0;
    jac_done = 1'b1; @(negedge clk); jac_done = 1'b0;
    repeat (6) @(negedge clk);
    chk("late_pulse_no_starts", {jcnt - j0, scnt - s0}, 64'd0);
    chk("late_pulse_idle", {busy, done, theta_out}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
